// File: rtl/subkey_sequencer.sv
// Threefish-1024 subkey sequencer: walks the 17-word key demux and emits one 16-word subkey per request.
// Optional macro SUBKEY_TWEAK_INJECT_EN enables tweak injection on words 13 and 14.
module subkey_sequencer #(
    parameter int MAX_SUBKEY = 20
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [4:0]   subkey_i,
    input  logic [127:0] tweak_i,
    output logic [4:0]   select_o,
    input  logic [63:0]  key_word_i,
    output logic [63:0]  word_o,
    output logic [3:0]   word_idx_o,
    output logic         word_valid_o,
    input  logic         word_ready_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam logic [4:0] MaxSubkeyC = 5'(MAX_SUBKEY);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [4:0]  subkey_q, subkey_d;
    logic [4:0]  sel_q, sel_d;
    logic [3:0]  idx_q, idx_d;
    logic [63:0] word_q, word_d;
    logic [3:0]  word_idx_q, word_idx_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [4:0]  s_mod17;
    logic        slot_free;
    logic [63:0] inj;

    assign s_mod17   = (subkey_i >= 5'd17) ? subkey_i - 5'd17 : subkey_i;
    assign slot_free = !valid_q || word_ready_i;

`ifdef SUBKEY_TWEAK_INJECT_EN
    logic [63:0] t0_q, t0_d;
    logic [63:0] t1_q, t1_d;
    logic [1:0]  tptr_q, tptr_d;
    logic [1:0]  tptr_next;
    logic [63:0] tw_a, tw_b;

    // tw_a is t[s mod 3] for word 13, tw_b is the following tweak word for word 14
    assign tptr_next = (tptr_q == 2'd2) ? 2'd0 : tptr_q + 2'd1;

    always_comb begin
        case (tptr_q)
            2'd0:    tw_a = t0_q;
            2'd1:    tw_a = t1_q;
            default: tw_a = t0_q ^ t1_q;
        endcase
        case (tptr_next)
            2'd0:    tw_b = t0_q;
            2'd1:    tw_b = t1_q;
            default: tw_b = t0_q ^ t1_q;
        endcase
    end

    always_comb begin
        inj = 64'd0;
        if (idx_q == 4'd15)      inj = {59'd0, subkey_q};
        else if (idx_q == 4'd14) inj = tw_b;
        else if (idx_q == 4'd13) inj = tw_a;
    end
`else
    logic unused_tweak;
    assign unused_tweak = ^tweak_i;

    always_comb begin
        inj = 64'd0;
        if (idx_q == 4'd15) inj = {59'd0, subkey_q};
    end
`endif

    always_comb begin
        state_d    = state_q;
        subkey_d   = subkey_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef SUBKEY_TWEAK_INJECT_EN
        t0_d       = t0_q;
        t1_d       = t1_q;
        tptr_d     = tptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (subkey_i > MaxSubkeyC) begin
                        err_d = 1'b1;
                    end else begin
                        subkey_d = subkey_i;
                        sel_d    = s_mod17;
                        idx_d    = 4'd0;
                        busy_d   = 1'b1;
                        state_d  = RUN;
`ifdef SUBKEY_TWEAK_INJECT_EN
                        t0_d     = tweak_i[63:0];
                        t1_d     = tweak_i[127:64];
                        tptr_d   = 2'(subkey_i % 5'd3);
`endif
                    end
                end
            end
            RUN: begin
                if (slot_free) begin
                    word_d     = key_word_i + inj;
                    word_idx_d = idx_q;
                    valid_d    = 1'b1;
                    idx_d      = idx_q + 4'd1;
                    // The demux select stays parked on the last word once word 15 is loaded
                    if (idx_q == 4'd15) begin
                        state_d = DRAIN;
                    end else begin
                        sel_d = (sel_q == 5'd16) ? 5'd0 : sel_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && word_ready_i) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            subkey_q   <= 5'd0;
            sel_q      <= 5'd0;
            idx_q      <= 4'd0;
            word_q     <= 64'd0;
            word_idx_q <= 4'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef SUBKEY_TWEAK_INJECT_EN
            t0_q       <= 64'd0;
            t1_q       <= 64'd0;
            tptr_q     <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            subkey_q   <= subkey_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef SUBKEY_TWEAK_INJECT_EN
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            tptr_q     <= tptr_d;
`endif
        end
    end

    assign select_o     = sel_q;
    assign word_o       = word_q;
    assign word_idx_o   = word_idx_q;
    assign word_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_subkey_sequencer.sv
// Scoreboard bench for subkey_sequencer; expected words come from a small key/tweak model.
module tb_subkey_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         ready = 1'b1;
    logic [4:0]   subkey = 5'd0;
    logic [127:0] tweak = 128'd0;
    logic [4:0]   select;
    logic [63:0]  key_word;
    logic [63:0]  word;
    logic [3:0]   word_idx;
    logic         valid, busy, done, err;

    logic [63:0]  kmem [17];
    logic [63:0]  got_w [16];

    typedef struct packed {
        logic [3:0]  idx;
        logic [63:0] word;
    } exp_t;

    exp_t exp_q[$];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int start_cyc = 0;
    int handshakes = 0;
    bit check_latency = 1'b0;

    localparam logic [127:0] TweakC = {64'h20, 64'h10};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign key_word = (select <= 5'd16) ? kmem[select] : 64'd0;

    subkey_sequencer #(.MAX_SUBKEY(20)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .subkey_i     (subkey),
        .tweak_i      (tweak),
        .select_o     (select),
        .key_word_i   (key_word),
        .word_o       (word),
        .word_idx_o   (word_idx),
        .word_valid_o (valid),
        .word_ready_i (ready),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

`ifdef SUBKEY_TWEAK_INJECT_EN
    function automatic logic [63:0] tweakWord(input int n, input logic [127:0] t);
        if (n == 0) return t[63:0];
        if (n == 1) return t[127:64];
        return t[63:0] ^ t[127:64];
    endfunction
`endif

    function automatic logic [63:0] modelWord(input int s, input int i, input logic [127:0] t);
        logic [63:0] w;
        w = kmem[(s + i) % 17];
        if (i == 15) w = w + 64'(s);
`ifdef SUBKEY_TWEAK_INJECT_EN
        if (i == 13) w = w + tweakWord(s % 3, t);
        if (i == 14) w = w + tweakWord((s + 1) % 3, t);
`endif
        return w;
    endfunction

    task automatic pushExpected(input int s, input logic [127:0] t);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.idx  = 4'(i);
            e.word = modelWord(s, i, t);
            exp_q.push_back(e);
        end
    endtask

    // Consumer side: every handshake pops one expected word
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid && ready) begin
            handshakes++;
            if (exp_q.size() == 0) begin
                checkOutput("extra_word", 64'(word_idx), 64'hdead);
            end else begin
                e = exp_q.pop_front();
                checkOutput("word", word, e.word);
                checkOutput("idx", 64'(word_idx), 64'(e.idx));
                got_w[word_idx] = word;
            end
        end
        if (rst_n && done) begin
            checkOutput("busy_at_done", 64'(busy), 64'd0);
            if (check_latency) checkOutput("done_latency", 64'(cyc - start_cyc), 64'd17);
        end
    end

    task automatic applyStimulus(input int s, input logic [127:0] t);
        @(posedge clk); #2;
        start  = 1'b1;
        subkey = 5'(s);
        tweak  = t;
        @(posedge clk); #2;
        start     = 1'b0;
        start_cyc = cyc;
        if (s <= 20) begin
            pushExpected(s, t);
            checkOutput("start_busy", 64'(busy), 64'd1);
            checkOutput("start_select", 64'(select), 64'(s % 17));
            checkOutput("start_valid", 64'(valid), 64'd0);
            checkOutput("start_err", 64'(err), 64'd0);
        end else begin
            checkOutput("err_pulse", 64'(err), 64'd1);
            checkOutput("err_busy", 64'(busy), 64'd0);
            checkOutput("err_valid", 64'(valid), 64'd0);
            @(posedge clk); #2;
            checkOutput("err_clear", 64'(err), 64'd0);
            checkOutput("err_busy2", 64'(busy), 64'd0);
        end
    endtask

    task automatic waitIdle();
        bit ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #2;
            if (!busy && !valid && !done && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic waitIdx(input logic [3:0] target, output bit found);
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #2;
            if (valid && word_idx == target) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic runSubkey(input int s);
        handshakes    = 0;
        check_latency = 1'b1;
        applyStimulus(s, TweakC);
        waitIdle();
        checkOutput("handshakes", 64'(handshakes), 64'd16);
    endtask

    initial begin
        bit found;
        for (int j = 0; j < 17; j++) kmem[j] = 64'h100 + 64'(j);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_select", 64'(select), 64'd0);
        checkOutput("rst_word", word, 64'd0);
        checkOutput("rst_idx", 64'(word_idx), 64'd0);
        checkOutput("rst_valid", 64'(valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;

        runSubkey(0);
`ifdef SUBKEY_TWEAK_INJECT_EN
        checkOutput("s0_w13", got_w[13], 64'h11D);
        checkOutput("s0_w14", got_w[14], 64'h12E);
`else
        checkOutput("s0_w13", got_w[13], 64'h10D);
        checkOutput("s0_w14", got_w[14], 64'h10E);
`endif
        checkOutput("s0_w15", got_w[15], 64'h10F);

        runSubkey(5);
        checkOutput("s5_w11", got_w[11], 64'h110);
        checkOutput("s5_w12", got_w[12], 64'h100);
        checkOutput("s5_w15", got_w[15], 64'h108);

        runSubkey(20);
        checkOutput("s20_w15", got_w[15], 64'h115);
        kmem[0] = 64'hFFFF_FFFF_FFFF_FFF5;
        runSubkey(20);
        checkOutput("s20_k0_w15", got_w[15], 64'h115);
        kmem[1] = 64'hFFFF_FFFF_FFFF_FFF5;
        runSubkey(20);
        checkOutput("s20_wrap_w15", got_w[15], 64'h9);
        kmem[0] = 64'h100;
        kmem[1] = 64'h101;

        // Hold the consumer off for three cycles while word 4 is presented
        handshakes    = 0;
        check_latency = 1'b0;
        applyStimulus(3, TweakC);
        waitIdx(4'd4, found);
        checkOutput("stall_found", 64'(found), 64'd1);
        ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            checkOutput("stall_word", word, 64'h107);
            checkOutput("stall_idx", 64'(word_idx), 64'd4);
            checkOutput("stall_select", 64'(select), 64'd8);
        end
        ready = 1'b1;
        waitIdle();
        checkOutput("stall_handshakes", 64'(handshakes), 64'd16);

        applyStimulus(21, TweakC);

        // Starts during a running subkey must be ignored
        handshakes    = 0;
        check_latency = 1'b1;
        applyStimulus(1, TweakC);
        start  = 1'b1;
        subkey = 5'd7;
        repeat (3) @(posedge clk);
        #2;
        start = 1'b0;
        waitIdle();
        checkOutput("busy_start_handshakes", 64'(handshakes), 64'd16);

        // Back-to-back: a start presented in the done cycle is taken
        applyStimulus(2, TweakC);
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #2;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("b2b_done_seen", 64'(found), 64'd1);
        start  = 1'b1;
        subkey = 5'd4;
        pushExpected(4, TweakC);
        @(posedge clk); #2;
        start      = 1'b0;
        start_cyc  = cyc;
        handshakes = 0;
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        checkOutput("b2b_select", 64'(select), 64'd4);
        waitIdle();
        checkOutput("b2b_handshakes", 64'(handshakes), 64'd16);

        // Asynchronous reset in the middle of a subkey
        check_latency = 1'b0;
        applyStimulus(0, TweakC);
        waitIdx(4'd7, found);
        checkOutput("rst_mid_found", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_select", 64'(select), 64'd0);
        checkOutput("arst_word", word, 64'd0);
        checkOutput("arst_idx", 64'(word_idx), 64'd0);
        checkOutput("arst_valid", 64'(valid), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_done", 64'(done), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        runSubkey(0);
`ifdef SUBKEY_TWEAK_INJECT_EN
        checkOutput("fresh_w13", got_w[13], 64'h11D);
`else
        checkOutput("fresh_w13", got_w[13], 64'h10D);
`endif
        checkOutput("fresh_w15", got_w[15], 64'h10F);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
